keccak_sponge_ctrl: RTL
=======================

// Module: keccak_sponge_ctrl
// PURPOSE
// Sequencer that sits in front of the single-cycle keccak sponge core. It packs a W-bit
// valid/ready byte stream into R-bit rate blocks and applies FIPS 202 pad10*1 with a
// domain-suffix byte. It pulses the core enable once per block, then captures the final
// digest and holds it until the consumer accepts it. It then clears the core for the
// next message.
// PARAMETERS
// D   256        digest width in bits; core capacity C = 2*D
// L   6          keccak lane exponent; B = 25*2**L (only L=6 supported)
// B   25*2**L    permutation width in bits
// R   B-2*D      rate in bits; must be a multiple of W (elaboration-time assert)
// W   64         input word width in bits; multiple of 8
// DS  8'h06      domain-suffix byte (8'h06 SHA3, 8'h1F SHAKE)
// PORTS
// clk          in   1              clock
// reset        in   1              asynchronous, active-high reset
// in_valid     in   1              input word valid
// in_ready     out  1              controller accepts a word this cycle
// in_data      in   W              message bytes, byte k at [8k+7:8k]
// in_last      in   1              word is the final word of the message
// in_bytes     in   $clog2(W/8)+1  valid bytes in a last word, 0..W/8; ignored unless in_last
// core_enable  out  1              one-cycle absorb strobe to core enable
// core_clear   out  1              one-cycle core state clear; core reset = reset | core_clear
// core_message out  R              rate block; word j at [j*W +: W]
// core_digest  in   D              core digest, valid in the core_enable cycle
// out_valid    out  1              digest register valid
// out_ready    in   1              consumer accepts the digest
// digest       out  D              registered digest, first digest byte at [7:0]
// BEHAVIOUR
// - Reset (async) values: state=FILL, word_idx=0, block buffer=0, pad_pending=0,
//   digest=0. The outputs are in_ready=1, core_enable=0, core_clear=0, out_valid=0.
// - FILL: in_ready=1. A handshake (in_valid&in_ready) writes in_data to buffer word
//   word_idx. Bytes at index >= in_bytes of a last word are written as 0.
//   word_idx increments on each handshake.
//   * Not last, block now full (word_idx was R/W-1): go to ABSORB.
//   * Last, bytes in block < R/8: go to PAD.
//   * Last, block exactly full: set pad_pending and go to ABSORB.
//   * in_bytes > W/8 is treated as W/8.
// - ABSORB (1 cycle): core_enable=1 and core_message=buffer. Then buffer<=0 and
//   word_idx<=0. If pad_pending, go to PAD (empty block); otherwise go to FILL.
// - PAD (1 cycle): let p = message bytes in the current block.
//   Then buffer byte p ^= DS and buffer byte R/8-1 ^= 8'h80.
//   If p = R/8-1, that byte becomes DS^8'h80 (8'h86 for SHA3). Clear pad_pending.
//   Go to FINAL.
// - FINAL (1 cycle): core_enable=1. digest <= core_digest, captured at the clock edge
//   ending this cycle. Go to OUT.
// - OUT: out_valid=1, and digest stays stable until out_ready. On handshake go to CLEAR.
// - CLEAR (1 cycle): core_clear=1, buffer=0. Go to FILL.
// - in_ready=0 in every state except FILL; core_enable=0 outside ABSORB and FINAL.
//   core_enable and core_clear are never high together.
// - Latency: last-word handshake at cycle t gives out_valid=1 at t+3. With an extra pad
//   block, out_valid=1 at t+4. in_ready returns 2 cycles after the out handshake.
// - Core state is never advanced except by core_enable, so the input may stall
//   indefinitely mid-block.
// - Reset mid-operation aborts the message. No partial digest is produced, and the
//   core is cleared by the shared reset.
// TESTING
// 1. Empty message (in_last=1, in_bytes=0) -> one core_enable pulse; block byte0=8'h06,
//    byte135=8'h80; digest[31:0]=32'hf8c6ffa7 (bytes a7 ff c6 f8...).
// 2. "abc" (in_data=64'h636261, in_bytes=3, last) -> block byte3=8'h06;
//    digest bytes start 3a 98 5d a7.
// 3. 136 bytes (17 full words, last on 17th) -> two core_enable pulses; the second block
//    has byte0=8'h06, byte135=8'h80, all else 0; out_valid at t+4.
// 4. 135 bytes (last word in_bytes=7) -> single core_enable in FINAL; byte135=8'h86.
// 5. out_ready low 10 cycles -> out_valid=1 and digest stable, in_ready=0. Then on
//    handshake, core_clear pulses once and in_ready=1 two cycles later.
// 6. reset asserted after 5 words with clk held -> in_ready=1, out_valid=0 immediately.
//    A following empty message still yields digest test 1.

Source files
------------

// File: rtl/keccak_sponge_ctrl_if.sv
// keccak_sponge_ctrl_if
// Groups the controller's message-input stream, its connection to the single-cycle
// keccak sponge core, and the digest output handshake.
//   in_valid/in_ready/in_data/in_last/in_bytes : byte-packed message word stream
//   core_enable/core_clear/core_message        : absorb strobe, state clear, rate block
//   core_digest                                : core digest (valid during core_enable)
//   out_valid/out_ready/digest                 : registered digest handshake
// The "slave" modport is the controller. The "master" modport is its environment,
// which is the message source, the core and the digest consumer.
interface keccak_sponge_ctrl_if #(
  parameter int W = 64,
  parameter int R = 1088,
  parameter int D = 256
);
  localparam int BW = $clog2(W / 8) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [BW-1:0] in_bytes;
  logic          core_enable;
  logic          core_clear;
  logic [R-1:0]  core_message;
  logic [D-1:0]  core_digest;
  logic          out_valid;
  logic          out_ready;
  logic [D-1:0]  digest;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_digest, out_ready,
    output in_ready, core_enable, core_clear, core_message, out_valid, digest
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_digest, out_ready,
    input  in_ready, core_enable, core_clear, core_message, out_valid, digest
  );
endinterface

// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl
// Sequencer in front of a single-cycle keccak sponge core. It packs W-bit message words
// into R-bit rate blocks and applies pad10*1 with the domain-suffix byte DS. It strobes
// the core once per block, captures the final digest and holds it until the consumer
// accepts it. It then clears the core for the next message.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset (the core also resets on it)
//   bus    : keccak_sponge_ctrl_if.slave, which carries the input stream, the core
//            strobes and rate block, the core digest and the digest output handshake
module keccak_sponge_ctrl #(
  parameter int         D  = 256,
  parameter int         L  = 6,
  parameter int         B  = 25 * (2 ** L),
  parameter int         R  = B - 2 * D,
  parameter int         W  = 64,
  parameter logic [7:0] DS = 8'h06
) (
  input  logic                clk,
  input  logic                reset,
  keccak_sponge_ctrl_if.slave bus
);
  localparam int WORDS = R / W;              // words per rate block
  localparam int WB    = W / 8;              // bytes per word
  localparam int RB    = R / 8;              // bytes per rate block
  localparam int BW    = $clog2(WB) + 1;     // width of in_bytes
  localparam int IW    = $clog2(WORDS + 1);  // word index width
  localparam int PW    = $clog2(RB + 1);     // byte position width

  generate
    if ((R % W) != 0) begin : g_bad_rate
      $error("keccak_sponge_ctrl: rate R must be a multiple of W");
    end
    if ((W % 8) != 0) begin : g_bad_width
      $error("keccak_sponge_ctrl: W must be a multiple of 8");
    end
    if (L != 6) begin : g_bad_lane
      $error("keccak_sponge_ctrl: only L=6 is supported");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_FILL, S_ABSORB, S_PAD, S_FINAL, S_OUT, S_CLEAR
  } state_t;

  state_t        state_reg;
  logic [IW-1:0] word_idx_reg;
  logic [R-1:0]  buf_reg;
  logic          pad_pending_reg;
  logic [PW-1:0] pad_pos_reg;
  logic [D-1:0]  digest_reg;
  logic          in_ready_reg;
  logic          core_enable_reg;
  logic          core_clear_reg;
  logic          out_valid_reg;

  // Valid byte count of the incoming word, clamped to a full word.
  logic [BW-1:0] nbytes;
  assign nbytes = (bus.in_bytes > BW'(WB)) ? BW'(WB) : bus.in_bytes;

  // Bytes beyond the valid count of a last word are zeroed before they reach the block.
  logic [W-1:0] word_masked;
  genvar gi;
  generate
    for (gi = 0; gi < WB; gi++) begin : g_mask
      assign word_masked[8*gi +: 8] =
        (!bus.in_last || (BW'(gi) < nbytes)) ? bus.in_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  logic          hs;
  logic          block_full;
  logic          last_full;
  logic [PW-1:0] fill_bytes;
  logic [R-1:0]  pad_mask;

  assign hs         = bus.in_valid & in_ready_reg;
  assign block_full = (word_idx_reg == IW'(WORDS - 1));
  assign last_full  = block_full && (nbytes == BW'(WB));
  assign fill_bytes = PW'(word_idx_reg) * PW'(WB) + PW'(nbytes);
  // The two pad bytes are XOR-merged. When the suffix lands on the final byte, the
  // result is DS^8'h80.
  assign pad_mask   = ({{(R-8){1'b0}}, DS} << {pad_pos_reg, 3'b000})
                    ^ {8'h80, {(R-8){1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_FILL;
      word_idx_reg    <= '0;
      buf_reg         <= '0;
      pad_pending_reg <= 1'b0;
      pad_pos_reg     <= '0;
      digest_reg      <= '0;
      in_ready_reg    <= 1'b1;
      core_enable_reg <= 1'b0;
      core_clear_reg  <= 1'b0;
      out_valid_reg   <= 1'b0;
    end else begin
      core_enable_reg <= 1'b0;
      core_clear_reg  <= 1'b0;
      case (state_reg)
        S_FILL: begin
          if (hs) begin
            buf_reg[word_idx_reg*W +: W] <= word_masked;
            word_idx_reg <= word_idx_reg + 1'b1;
            if (bus.in_last) begin
              in_ready_reg <= 1'b0;
              if (last_full) begin
                // The message filled the block exactly, so padding needs a block of its own.
                pad_pending_reg <= 1'b1;
                core_enable_reg <= 1'b1;
                state_reg       <= S_ABSORB;
              end else begin
                pad_pos_reg <= fill_bytes;
                state_reg   <= S_PAD;
              end
            end else if (block_full) begin
              in_ready_reg    <= 1'b0;
              core_enable_reg <= 1'b1;
              state_reg       <= S_ABSORB;
            end
          end
        end
        S_ABSORB: begin
          buf_reg      <= '0;
          word_idx_reg <= '0;
          if (pad_pending_reg) begin
            pad_pos_reg <= '0;
            state_reg   <= S_PAD;
          end else begin
            in_ready_reg <= 1'b1;
            state_reg    <= S_FILL;
          end
        end
        S_PAD: begin
          buf_reg         <= buf_reg ^ pad_mask;
          pad_pending_reg <= 1'b0;
          core_enable_reg <= 1'b1;
          state_reg       <= S_FINAL;
        end
        S_FINAL: begin
          digest_reg    <= bus.core_digest;
          out_valid_reg <= 1'b1;
          state_reg     <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_reg  <= 1'b0;
            core_clear_reg <= 1'b1;
            state_reg      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          buf_reg      <= '0;
          word_idx_reg <= '0;
          in_ready_reg <= 1'b1;
          state_reg    <= S_FILL;
        end
        default: begin
          in_ready_reg <= 1'b1;
          state_reg    <= S_FILL;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.core_enable  = core_enable_reg;
  assign bus.core_clear   = core_clear_reg;
  assign bus.core_message = buf_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.digest       = digest_reg;
endmodule
